syndrome_check: RTL

//   Downstream stage of the decoder output layer. Takes the per-variable-node output LLR vector,

---
 rtl/syndrome_check.sv | 131 +++++++++++++
 1 files changed

// File: rtl/syndrome_check.sv
// Hard-decision parity checker for the decoder output layer: one check row per cycle, then a held result.
// Build option SYNDROME_EARLY_EXIT_EN: stop scanning at the first unsatisfied row.
module syndrome_check #(
    parameter int N_V      = 44,
    parameter int N_C      = 12,
    parameter int N_FP     = 8,
    parameter int MAX_ITER = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [0:N_C-1][0:N_V-1]         h_matrix,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [0:N_V-1][N_FP-1:0]        in_llr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_V-1:0]                  out_bits,
    output logic                            out_ok,
    output logic [$clog2(N_C+1)-1:0]        out_fail_cnt,
    output logic                            out_stop,
    output logic [$clog2(MAX_ITER)-1:0]     out_iter
);

    localparam int CI_W = (N_C > 1) ? $clog2(N_C) : 1;
    localparam int FC_W = $clog2(N_C + 1);
    localparam int IT_W = $clog2(MAX_ITER);

`ifdef SYNDROME_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CHECK, RESULT} state_t;

    state_t            state_q, state_d;
    logic [N_V-1:0]    bits_q, bits_d;
    logic [CI_W-1:0]   c_idx_q, c_idx_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic              ok_q, ok_d;
    logic [N_V-1:0]    hard_bits;
    logic              parity;
    logic              last_row;
    logic              unused_llr;

    // Only the sign bit of each LLR matters for the hard decision.
    assign unused_llr = ^in_llr;

    always_comb begin
        hard_bits = '0;
        for (int v = 0; v < N_V; v++) begin
            hard_bits[v] = in_llr[v][N_FP-1];
        end
    end

    always_comb begin
        parity = 1'b0;
        for (int v = 0; v < N_V; v++) begin
            parity = parity ^ (bits_q[v] & h_matrix[c_idx_q][v]);
        end
    end

    assign last_row = (c_idx_q == CI_W'(N_C - 1));

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        c_idx_d = c_idx_q;
        fail_d  = fail_q;
        iter_d  = iter_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bits_d  = hard_bits;
                    c_idx_d = '0;
                    fail_d  = '0;
                    ok_d    = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (parity) begin
                    fail_d = fail_q + FC_W'(1);
                end
                if (last_row || (EARLY_EXIT && parity)) begin
                    ok_d    = (fail_d == '0);
                    state_d = RESULT;
                end else begin
                    c_idx_d = c_idx_q + CI_W'(1);
                end
            end
            RESULT: begin
                // A stop (clean word or last allowed pass) restarts the iteration count.
                if (out_ready) begin
                    iter_d  = out_stop ? '0 : iter_q + IT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bits_q  <= '0;
            c_idx_q <= '0;
            fail_q  <= '0;
            iter_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            c_idx_q <= c_idx_d;
            fail_q  <= fail_d;
            iter_q  <= iter_d;
            ok_q    <= ok_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == RESULT);
    assign out_bits     = bits_q;
    assign out_ok       = ok_q;
    assign out_fail_cnt = fail_q;
    assign out_iter     = iter_q;
    assign out_stop     = ok_q | (iter_q == IT_W'(MAX_ITER - 1));

endmodule
